// File: rtl/pc_pipe_acc.sv
// Pipelined popcount with valid/ready handshakes and per-packet saturating accumulation.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_count/out_sat.
module pc_pipe_acc #(
  parameter int N      = 15,
  parameter int STAGES = 2,
  parameter int ACC_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int G  = (N + 14) / 15;
  localparam int XW = G * 15;
  localparam int CW = $clog2(N + 1);

  if (N < 1) begin : g_chk_n
    $error("pc_pipe_acc: N must be >= 1");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_chk_s
    $error("pc_pipe_acc: STAGES must be 1..4");
  end
  if (ACC_W < CW) begin : g_chk_w
    $error("pc_pipe_acc: ACC_W too narrow");
  end

  function automatic logic [3:0] pop15(
    input logic [14:0] x
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      r = r + 4'(x[i]);
    end
    return r;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [XW-1:0] din;
  assign din = XW'(in_data);

  logic [3:0] grp [G];
  always_comb begin
    for (int g = 0; g < G; g++) begin
      grp[g] = pop15(din[g*15 +: 15]);
    end
  end

  // Word descriptor entering the accumulator stage.
  logic          fin_v;
  logic          fin_l;
  logic [CW-1:0] fin_c;

  if (STAGES == 1) begin : g_one
    logic [CW-1:0] tot;
    always_comb begin
      tot = '0;
      for (int g = 0; g < G; g++) begin
        tot = tot + CW'(grp[g]);
      end
    end
    assign fin_v = in_valid;
    assign fin_l = in_last;
    assign fin_c = tot;
  end else begin : g_pipe
    logic          s1_v;
    logic          s1_l;
    logic [3:0]    s1_g [G];
    logic [CW-1:0] tot;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v <= 1'b0;
        s1_l <= 1'b0;
        for (int g = 0; g < G; g++) begin
          s1_g[g] <= '0;
        end
      end else if (adv) begin
        s1_v <= in_valid;
        s1_l <= in_last;
        for (int g = 0; g < G; g++) begin
          s1_g[g] <= grp[g];
        end
      end
    end

    always_comb begin
      tot = '0;
      for (int g = 0; g < G; g++) begin
        tot = tot + CW'(s1_g[g]);
      end
    end

    if (STAGES == 2) begin : g_two
      assign fin_v = s1_v;
      assign fin_l = s1_l;
      assign fin_c = tot;
    end else begin : g_deep
      localparam int D = STAGES - 2;
      logic          d_v [D];
      logic          d_l [D];
      logic [CW-1:0] d_c [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            d_v[k] <= 1'b0;
            d_l[k] <= 1'b0;
            d_c[k] <= '0;
          end
        end else if (adv) begin
          d_v[0] <= s1_v;
          d_l[0] <= s1_l;
          d_c[0] <= tot;
          for (int k = 1; k < D; k++) begin
            d_v[k] <= d_v[k-1];
            d_l[k] <= d_l[k-1];
            d_c[k] <= d_c[k-1];
          end
        end
      end

      assign fin_v = d_v[D-1];
      assign fin_l = d_l[D-1];
      assign fin_c = d_c[D-1];
    end
  end

  // Accumulator stage.
  logic [ACC_W-1:0] acc;
  logic             sat_st;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] nt;
  logic             ns;

  always_comb begin
    sum = {1'b0, acc} + (ACC_W+1)'(fin_c);
    nt  = sum[ACC_W-1:0];
    ns  = sat_st;
    // Carry out means the total passed the all-ones ceiling.
    if (sum[ACC_W]) begin
      nt = '1;
      ns = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat_st    <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (fin_v) begin
        if (fin_l) begin
          out_valid <= 1'b1;
          out_count <= nt;
          out_sat   <= ns;
          acc       <= '0;
          sat_st    <= 1'b0;
        end else begin
          acc    <= nt;
          sat_st <= ns;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_pipe_acc.sv
// Self-checking bench for pc_pipe_acc (N=15, STAGES=2, ACC_W=8).
// Directed vector table plus hand sequences for backpressure and reset.
module tb_pc_pipe_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_count;
  logic        out_sat;

  pc_pipe_acc #(.N(15), .STAGES(2), .ACC_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] data;
    logic        last;
    logic        ev;
    int          ec;
    logic        es;
  } vec_t;

  vec_t vecs [64];
  int   nv;
  int   total;
  int   passed;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  task automatic add(input logic [14:0] d, input logic l,
                     input logic ev, input int ec, input logic es);
    vecs[nv].data = d;
    vecs[nv].last = l;
    vecs[nv].ev   = ev;
    vecs[nv].ec   = ec;
    vecs[nv].es   = es;
    nv++;
  endtask

  initial begin
    int          idx;
    int          nrx;
    int          held;
    bit          held_v;
    bit          acc_w;
    bit          hs;
    int          cnt;
    int          q [$];
    logic [14:0] w;

    total = 0;
    passed = 0;
    nv = 0;

    add(15'h0000, 1, 1, 0, 0);
    add(15'h7FFF, 1, 1, 15, 0);
    add(15'h5555, 1, 1, 8, 0);
    add(15'h0001, 1, 1, 1, 0);
    add(15'h7FFF, 0, 0, 0, 0);
    add(15'h0001, 0, 0, 0, 0);
    add(15'h00FF, 1, 1, 24, 0);
    add(15'h4000, 1, 1, 1, 0);
    for (int i = 0; i < 16; i++) add(15'h7FFF, 0, 0, 0, 0);
    add(15'h7FFF, 1, 1, 255, 0);
    for (int i = 0; i < 17; i++) add(15'h7FFF, 0, 0, 0, 0);
    add(15'h7FFF, 1, 1, 255, 1);
    add(15'h0003, 1, 1, 2, 0);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_sat", out_sat, 0);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i <= nv; i++) begin
      if (i < nv) begin
        in_valid = 1'b1;
        in_data = vecs[i].data;
        in_last = vecs[i].last;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check($sformatf("vec%0d_ready", i), in_ready, 1);
      @(posedge clk);
      #1;
      if (i > 0) begin
        check($sformatf("vec%0d_valid", i-1), out_valid, vecs[i-1].ev);
        if (vecs[i-1].ev) begin
          check($sformatf("vec%0d_count", i-1), out_count, vecs[i-1].ec);
          check($sformatf("vec%0d_sat", i-1), out_sat, vecs[i-1].es);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", out_valid, 0);

    // Backpressure: stream of single-word packets, consumer stalls 5 cycles.
    idx = 0;
    nrx = 0;
    held = 0;
    held_v = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid = (idx < 12);
      w = 15'((1 << (idx + 1)) - 1);
      in_data = w;
      in_last = 1'b1;
      #1;
      if (out_valid && !out_ready) begin
        check($sformatf("bp%0d_in_ready", c), in_ready, 0);
        if (held_v) check($sformatf("bp%0d_hold", c), out_count, held);
        held = out_count;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      acc_w = in_valid && in_ready;
      hs = out_valid && out_ready;
      cnt = out_count;
      @(posedge clk);
      #1;
      if (acc_w) begin
        q.push_back(idx + 1);
        idx++;
      end
      if (hs) begin
        if (q.size() == 0) begin
          check($sformatf("bp%0d_spurious", c), 1, 0);
        end else begin
          check($sformatf("bp%0d_count", c), cnt, q.pop_front());
          nrx++;
        end
      end
    end
    check("bp_received", nrx, 12);
    check("bp_pending", q.size(), 0);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-packet discards the partial 30.
    in_valid = 1'b1;
    in_data = 15'h7FFF;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 15'h0003;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_rst_lat1", out_valid, 0);
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 1);
    check("mid_rst_out_count", out_count, 2);
    check("mid_rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1;
    check("mid_rst_done", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_pipe_acc.md
# pc_pipe_acc

Parametrised, pipelined parallel counter (popcount) with valid/ready handshakes and packet accumulation. It is the clocked successor to the fixed 15-input/4-output parallel counters. It accepts one N-bit word per cycle and sums the counts of every word in a packet delimited by `in_last`. It emits one saturating total per packet. It sits between a streaming source, such as a switch sampler or sorting-network front end, and a consumer that may apply backpressure.

## Interface

Parameters:
- `N`, 15: input word width; must be ≥ 1.
- `STAGES`, 2: pipeline latency in cycles; must be 1..4.
- `ACC_W`, 8: width of the accumulator and output; must be ≥ `$clog2(N+1)`. Elaboration fails if it is not.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_data`/`in_last` are valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  N  word whose 1-bits are counted.
- `in_last`  input  1  word closes the current packet.
- `out_valid`  output  1  `out_count`/`out_sat` hold a packet result.
- `out_ready`  input  1  consumer accepts the result.
- `out_count`  output  ACC_W  packet total: sum of popcounts, saturated.
- `out_sat`  output  1  packet total hit saturation.

## Operation

- **Accept:** a word is accepted on a rising edge where `in_valid && in_ready`.
- **Pipeline:** `STAGES` register stages, each holding a valid bit, a `last` flag and a partial count.
  - Stage 1 registers exact popcounts of 15-bit groups of `in_data`, zero-extended as needed.
  - Middle stages reduce the group counts through an adder tree.
  - The final stage holds the accumulator.
  - Internal partitioning is free, provided the result equals the exact popcount and latency is exactly `STAGES`.
- **Advance:** `advance = !out_valid || out_ready`. All stages shift together only when `advance=1`.
  - `in_ready = advance`, a combinational path from `out_ready`.
  - Bubbles are carried through the pipeline, not compressed.
- **Final stage, valid word with count c:**
  - Compute `sum = acc + c` at width `ACC_W+1`.
  - If `sum > 2^ACC_W-1`: the new total is `2^ACC_W-1` and the sticky saturation flag is set.
  - If `last=0`: store the new total in `acc`; `out_valid` stays 0, so no output is produced.
  - If `last=1`: load `out_count` with the new total and `out_sat` with the sticky flag, set `out_valid=1`, then clear `acc` and the sticky flag to 0.
- **Single-word packet** (`in_last=1` on every word): behaves as a plain registered popcount.
- **Output hold:** `out_count`, `out_sat` and `out_valid` remain stable while `out_valid && !out_ready`.
- **Simultaneous events:** when `out_valid && out_ready` and a new last-word reaches the final stage in the same cycle, the new result replaces the old one with no gap. Throughput is one result per cycle.
- **Reset:** `rst_n` low asynchronously clears all stage valid bits, partial counts, `acc` and the sticky flag.
  - Outputs while in reset: `out_valid=0`, `out_count=0`, `out_sat=0`.
  - Any in-flight or partial packet is discarded. The first word after release starts a new packet.

## Timing

- Reset values: `out_valid=0`, `out_count=0`, `out_sat=0`, `in_ready=1`. Words presented while `rst_n=0` are ignored.
- Latency: a last-word accepted at edge k gives `out_valid=1` after edge k+`STAGES`, provided `advance` holds.
- Each cycle with `advance=0` adds one cycle of latency to every word in flight.
- Non-last words never raise `out_valid`.
- Result handoff completes on the edge where `out_valid && out_ready`. `out_valid` falls after that edge unless another result arrives in the same cycle.
- No word is dropped or duplicated under any `in_valid`/`out_ready` pattern.

## Test plan

Use `N=15`, `STAGES=2`, `ACC_W=8`.

1. **Reset:** hold `rst_n=0` for 3 cycles, then release → `out_valid=0`, `out_count=0`, `out_sat=0`, `in_ready=1`.
2. **Back-to-back single-word packets:** words `0x0000`, `0x7FFF`, `0x5555`, `0x0001`, all with `in_last=1`, `out_ready=1` → outputs 0, 15, 8, 1 on consecutive cycles, first result 2 cycles after first accept.
3. **Multi-word packet:** `0x7FFF`, `0x0001`, `0x00FF` (last on third word) → exactly one result, `out_count=24`, `out_sat=0`.
4. **Backpressure:** continuous stream of words with `in_last=1`, `out_ready` low for 5 cycles mid-stream.
   - `in_ready` drops the same cycle.
   - `out_count` is held stable.
   - Full sequence arrives in order with no loss or duplication.
5. **Saturation:** 18 words of `0x7FFF`, last on the 18th (true sum 270) → `out_count=255`, `out_sat=1`. Next packet `0x0003` (last) → `out_count=2`, `out_sat=0`.
6. **Reset mid-packet:** accept 2 non-last `0x7FFF` words, pulse `rst_n` low asynchronously, then send `0x0003` with last → `out_count=2`. No stale 30 appears.
